// File: rtl/mp_sync_fifo.sv
// mp_sync_fifo: multi-port synchronous FIFO; each cycle admits a whole write group and a whole read group, or rejects it.
// Optional feature: define MP_FIFO_PREFILL_EN to have reset load mem[i] = INIT_BASE + i and start full (free-list startup).
module mp_sync_fifo #(
    parameter int unsigned DEPTH     = 32,
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned W_PORTS   = 4,
    parameter int unsigned R_PORTS   = 4,
    parameter int unsigned INIT_BASE = 32,
    localparam int unsigned PTR_W    = $clog2(DEPTH) + 1,
    localparam int unsigned WC_W     = $clog2(W_PORTS + 1),
    localparam int unsigned RC_W     = $clog2(R_PORTS + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WC_W-1:0]            w_cnt,
    input  logic [W_PORTS*WIDTH-1:0]   din,
    input  logic [RC_W-1:0]            r_cnt,
    output logic [R_PORTS*WIDTH-1:0]   dout,
    output logic [R_PORTS-1:0]         dout_vld,
    output logic [PTR_W-1:0]           count,
    output logic                       full,
    output logic                       empty,
    output logic [PTR_W-1:0]           w_ptr,
    output logic [PTR_W-1:0]           r_ptr,
    output logic                       w_fail,
    output logic                       r_fail,
    input  logic                       change_w_ptr_en,
    input  logic                       change_r_ptr_en,
    input  logic [PTR_W-1:0]           change_w_ptr_value,
    input  logic [PTR_W-1:0]           change_r_ptr_value
);

    localparam int unsigned AW = PTR_W - 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] free;
    logic             w_acc;
    logic             r_acc;
    logic [AW-1:0]    waddr [W_PORTS];
    logic [AW-1:0]    raddr [R_PORTS];

    // The extra pointer bit distinguishes full (count == DEPTH) from empty.
    assign count = w_ptr - r_ptr;
    assign free  = PTR_W'(DEPTH) - count;
    assign full  = (count == PTR_W'(DEPTH));
    assign empty = (count == '0);

    assign w_acc  = (32'(w_cnt) <= W_PORTS) && (32'(w_cnt) <= 32'(free)) && !change_w_ptr_en;
    assign r_acc  = (32'(r_cnt) <= R_PORTS) && (32'(r_cnt) <= 32'(count)) && !change_r_ptr_en;
    assign w_fail = (w_cnt != '0) && !w_acc;
    assign r_fail = (r_cnt != '0) && !r_acc;

    always_comb begin
        for (int unsigned i = 0; i < W_PORTS; i++) begin
            waddr[i] = w_ptr[AW-1:0] + AW'(i);
        end
    end

    always_comb begin
        dout     = '0;
        dout_vld = '0;
        for (int unsigned i = 0; i < R_PORTS; i++) begin
            raddr[i]                = r_ptr[AW-1:0] + AW'(i);
            dout[i*WIDTH +: WIDTH]  = mem[raddr[i]];
            dout_vld[i]             = (PTR_W'(i) < count);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ptr <= '0;
`ifdef MP_FIFO_PREFILL_EN
            w_ptr <= PTR_W'(DEPTH);
`else
            w_ptr <= '0;
`endif
        end else begin
            if (change_w_ptr_en) begin
                w_ptr <= change_w_ptr_value;
            end else if (w_acc) begin
                w_ptr <= w_ptr + PTR_W'(w_cnt);
            end
            if (change_r_ptr_en) begin
                r_ptr <= change_r_ptr_value;
            end else if (r_acc) begin
                r_ptr <= r_ptr + PTR_W'(r_cnt);
            end
        end
    end

    // Storage is only initialised when prefill is enabled; otherwise reset leaves it alone.
    always_ff @(posedge clk) begin
        if (!reset) begin
`ifdef MP_FIFO_PREFILL_EN
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[AW'(i)] <= WIDTH'(INIT_BASE + i);
            end
`endif
        end else if (w_acc) begin
            for (int unsigned i = 0; i < W_PORTS; i++) begin
                if (WC_W'(i) < w_cnt) begin
                    mem[waddr[i]] <= din[i*WIDTH +: WIDTH];
                end
            end
        end
    end

endmodule
